red_pitaya_pid_ramp: RTL and testbench
======================================

RED_PITAYA_PID_RAMP -- requirements
Module: red_pitaya_pid_ramp

Interface
REQ-001 SHALL have parameter DW, default 14, setpoint data width (signed two's complement).
REQ-002 SHALL have port clk_i, input, 1, processing clock; single clock domain.
REQ-003 SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port sp_o, output, DW, ramped setpoint, driven to a PID block set-point input.
REQ-005 SHALL have port irst_o, output, 1, integrator reset request, driven to a PID block integrator reset input.
REQ-006 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-007 SHALL have ports sys_addr (in, 32), sys_wdata (in, 32), sys_sel (in, 4, ignored), sys_wen (in, 1), sys_ren (in, 1), sys_rdata (out, 32), sys_err (out, 1), sys_ack (out, 1), system bus slave.

Function
REQ-008 SHALL decode sys_addr[19:0]: 0x00 CTRL (W: bit0 start, bit1 abort; R/W: bit2 irst_en), 0x04 STATUS (R: bit0 busy, bit1 done, bits[3:2] state), 0x08 TARGET (R/W, DW bits), 0x0C STEP (R/W, 13 bits unsigned), 0x10 INTERVAL (R/W, 32 bits), 0x14 CURRENT (R/W, sp_o), 0x18 IRST_LEN (R/W, 16 bits).
REQ-009 SHALL assert sys_ack one cycle after sys_wen|sys_ren for every address; sys_err SHALL always be 0; unmapped reads SHALL return 0; unused rdata bits SHALL be 0.
REQ-010 SHALL implement states IDLE=0, IRST=1, RAMP=2; encoding reported in STATUS[3:2].
REQ-011 IDLE + start: latch TARGET into an internal target register, clear done, load interval counter to 0; go IRST if irst_en=1 and IRST_LEN!=0, else RAMP.
REQ-012 IRST: irst_o=1 for exactly IRST_LEN cycles, counted from the first cycle in IRST; then RAMP with irst_o=0.
REQ-013 RAMP: interval counter increments each cycle; when counter = max(INTERVAL,1)-1, counter clears and sp_o takes one step toward the latched target.
REQ-014 Step rule: diff = target - sp_o computed at DW+1 bits signed; effective step = max(STEP,1); if |diff| <= step then sp_o <= target, done <= 1, state <= IDLE; else sp_o <= sp_o ± step (sign of diff). sp_o SHALL never pass target nor wrap.
REQ-015 RAMP entered with sp_o = target SHALL set done and return to IDLE at the first step event without changing sp_o.
REQ-016 abort in any state: next state IDLE, irst_o=0, sp_o holds, done unchanged; abort and start written together: abort wins.
REQ-017 start while busy SHALL be ignored; writes to TARGET, STEP, INTERVAL, IRST_LEN while busy SHALL update registers but not affect the latched target; STEP/INTERVAL changes SHALL take effect at the next step event.
REQ-018 Write to CURRENT SHALL load sp_o only in IDLE; ignored while busy.
REQ-019 start and abort bits SHALL be single-cycle pulses, not stored; they read back as 0.
REQ-020 Register changes SHALL take effect the cycle after the write; sp_o and irst_o SHALL be registered outputs.

Reset
REQ-021 rstn_i low SHALL immediately force: state IDLE, sp_o=0, irst_o=0, busy_o=0, done=0, all config registers 0, counters 0, sys_ack=0, sys_err=0, sys_rdata=0.
REQ-022 Reset asserted mid-ramp or mid-IRST SHALL abandon the operation; after release the block SHALL be in IDLE with no pending start.

Verification
REQ-023 TARGET=100, STEP=30, INTERVAL=4, irst_en=0, start -> sp_o 30,60,90,100 at 4-cycle spacing; done=1, busy_o=0 after the 100 step.
REQ-024 CURRENT=50, TARGET=-8192, STEP=8191, INTERVAL=1, start -> sp_o 50, -8141, -8192; no wrap, done=1.
REQ-025 irst_en=1, IRST_LEN=5, TARGET=10, STEP=10, INTERVAL=2 -> irst_o high exactly 5 cycles, then sp_o=10 two cycles later, done=1.
REQ-026 Ramp 0->1000 STEP=1 INTERVAL=1, abort after 20 steps -> sp_o holds 20, IDLE, done=0; simultaneous start+abort from IDLE -> stays IDLE.
REQ-027 rstn_i pulsed low mid-ramp (sp_o=300) -> sp_o=0, irst_o=0, all registers read 0; any read/write acks one cycle later, unmapped 0x1C reads 0.

Source files
------------

// File: rtl/red_pitaya_pid_ramp.sv
// Set-point ramp generator for a PID block: steps sp_o toward a latched target at a
// programmable interval, with an optional integrator-reset pulse before the ramp.
module red_pitaya_pid_ramp #(
   parameter int DW = 14
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   output logic [DW-1:0] sp_o,
   output logic          irst_o,
   output logic          busy_o,
   input  logic [31:0]   sys_addr,
   input  logic [31:0]   sys_wdata,
   input  logic [3:0]    sys_sel,
   input  logic          sys_wen,
   input  logic          sys_ren,
   output logic [31:0]   sys_rdata,
   output logic          sys_err,
   output logic          sys_ack
);

   localparam int unsigned SW = 13;
   localparam int unsigned LW = 16;
   localparam int unsigned AW = 20;

   localparam logic [AW-1:0] A_CTRL     = 20'h00;
   localparam logic [AW-1:0] A_STATUS   = 20'h04;
   localparam logic [AW-1:0] A_TARGET   = 20'h08;
   localparam logic [AW-1:0] A_STEP     = 20'h0C;
   localparam logic [AW-1:0] A_INTERVAL = 20'h10;
   localparam logic [AW-1:0] A_CURRENT  = 20'h14;
   localparam logic [AW-1:0] A_IRST_LEN = 20'h18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IRST = 2'd1,
      ST_RAMP = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   target_r;
   logic [SW-1:0]   step_r;
   logic [31:0]     interval_r;
   logic [LW-1:0]   irst_len_r;
   logic            irst_en;
   logic [DW-1:0]   tgt_lat, tgt_nxt;
   logic [DW-1:0]   sp_nxt;
   logic            done, done_nxt;
   logic            irst_nxt;
   logic [31:0]     cnt, cnt_nxt;
   logic [LW-1:0]   irst_cnt, irst_cnt_nxt;

   logic [AW-1:0]   addr_c;
   logic            start_c, abort_c, cur_wr_c;
   logic [SW-1:0]   step_eff_c;
   logic [31:0]     last_c, abs_c;
   logic signed [31:0] sp_c, tgt_c, diff_c, step_c, moved_c;
   logic [31:0]     rdata_c;
   logic            unused_c;

   assign unused_c = ^{sys_sel, sys_addr[31:AW]};

   assign addr_c   = sys_addr[AW-1:0];
   assign start_c  = sys_wen && (addr_c == A_CTRL) && sys_wdata[0];
   assign abort_c  = sys_wen && (addr_c == A_CTRL) && sys_wdata[1];
   assign cur_wr_c = sys_wen && (addr_c == A_CURRENT);

   // Step arithmetic done at 32 bits signed so neither the difference nor the move can wrap.
   assign step_eff_c = (step_r == '0) ? SW'(1) : step_r;
   assign last_c     = (interval_r == '0) ? 32'd0 : interval_r - 32'd1;
   assign sp_c       = 32'($signed(sp_o));
   assign tgt_c      = 32'($signed(tgt_lat));
   assign diff_c     = tgt_c - sp_c;
   assign abs_c      = diff_c[31] ? 32'(-diff_c) : 32'(diff_c);
   assign step_c     = 32'(step_eff_c);
   assign moved_c    = diff_c[31] ? (sp_c - step_c) : (sp_c + step_c);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= ST_IDLE;
         sp_o     <= '0;
         irst_o   <= 1'b0;
         busy_o   <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         irst_cnt <= '0;
         tgt_lat  <= '0;
      end else begin
         state    <= state_nxt;
         sp_o     <= sp_nxt;
         irst_o   <= irst_nxt;
         busy_o   <= (state_nxt != ST_IDLE);
         done     <= done_nxt;
         cnt      <= cnt_nxt;
         irst_cnt <= irst_cnt_nxt;
         tgt_lat  <= tgt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      sp_nxt       = sp_o;
      done_nxt     = done;
      irst_nxt     = 1'b0;
      cnt_nxt      = cnt;
      irst_cnt_nxt = irst_cnt;
      tgt_nxt      = tgt_lat;
      case (state)
         ST_IDLE: begin
            if (abort_c) begin
               state_nxt = ST_IDLE;
            end else if (start_c) begin
               tgt_nxt  = target_r;
               done_nxt = 1'b0;
               cnt_nxt  = '0;
               if (irst_en && (irst_len_r != '0)) begin
                  state_nxt    = ST_IRST;
                  irst_nxt     = 1'b1;
                  irst_cnt_nxt = irst_len_r;
               end else begin
                  state_nxt = ST_RAMP;
               end
            end else if (cur_wr_c) begin
               sp_nxt = sys_wdata[DW-1:0];
            end
         end
         ST_IRST: begin
            if (abort_c) begin
               state_nxt = ST_IDLE;
            end else if (irst_cnt <= LW'(1)) begin
               state_nxt = ST_RAMP;
            end else begin
               irst_nxt     = 1'b1;
               irst_cnt_nxt = irst_cnt - LW'(1);
            end
         end
         ST_RAMP: begin
            if (abort_c) begin
               state_nxt = ST_IDLE;
            end else if (cnt >= last_c) begin
               cnt_nxt = '0;
               if (abs_c <= 32'(step_eff_c)) begin
                  sp_nxt    = tgt_lat;
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  sp_nxt = DW'(moved_c);
               end
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Configuration registers; writable at any time, only start latches the target.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         irst_en    <= 1'b0;
         target_r   <= '0;
         step_r     <= '0;
         interval_r <= '0;
         irst_len_r <= '0;
      end else if (sys_wen) begin
         case (addr_c)
            A_CTRL:     irst_en    <= sys_wdata[2];
            A_TARGET:   target_r   <= sys_wdata[DW-1:0];
            A_STEP:     step_r     <= sys_wdata[SW-1:0];
            A_INTERVAL: interval_r <= sys_wdata;
            A_IRST_LEN: irst_len_r <= sys_wdata[LW-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_c = '0;
      case (addr_c)
         A_CTRL:     rdata_c = {29'd0, irst_en, 2'b00};
         A_STATUS:   rdata_c = {28'd0, state, done, busy_o};
         A_TARGET:   rdata_c = 32'(target_r);
         A_STEP:     rdata_c = 32'(step_r);
         A_INTERVAL: rdata_c = interval_r;
         A_CURRENT:  rdata_c = 32'(sp_o);
         A_IRST_LEN: rdata_c = 32'(irst_len_r);
         default:    rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sys_ack   <= 1'b0;
         sys_err   <= 1'b0;
         sys_rdata <= '0;
      end else begin
         sys_ack   <= sys_wen | sys_ren;
         sys_err   <= 1'b0;
         sys_rdata <= sys_ren ? rdata_c : 32'd0;
      end
   end

endmodule

// File: tb/tb_red_pitaya_pid_ramp.sv
// Randomized bench for red_pitaya_pid_ramp: ramps are predicted from the step rule as a
// sequence of set-points plus their timing, then compared every cycle.
module tb_red_pitaya_pid_ramp;

   localparam int DW = 14;
   localparam logic [31:0] A_CTRL     = 32'h00;
   localparam logic [31:0] A_STATUS   = 32'h04;
   localparam logic [31:0] A_TARGET   = 32'h08;
   localparam logic [31:0] A_STEP     = 32'h0C;
   localparam logic [31:0] A_INTERVAL = 32'h10;
   localparam logic [31:0] A_CURRENT  = 32'h14;
   localparam logic [31:0] A_IRST_LEN = 32'h18;
   localparam logic [31:0] A_UNMAP    = 32'h1C;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic [DW-1:0] sp_o;
   logic          irst_o, busy_o;
   logic [31:0]   sys_addr, sys_wdata, sys_rdata;
   logic [3:0]    sys_sel;
   logic          sys_wen, sys_ren, sys_err, sys_ack;

   int checks = 0;
   int errors = 0;

   red_pitaya_pid_ramp #(.DW(DW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .sp_o(sp_o), .irst_o(irst_o), .busy_o(busy_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel), .sys_wen(sys_wen),
      .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk_i);
      sys_addr = addr; sys_wdata = data; sys_wen = 1'b1;
      @(posedge clk_i);
      #1;
      sys_wen = 1'b0;
      check("wr_ack", int'(sys_ack), 1);
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk_i);
      sys_addr = addr; sys_ren = 1'b1;
      @(posedge clk_i);
      #1;
      sys_ren = 1'b0;
      check("rd_ack", int'(sys_ack), 1);
      data = sys_rdata;
   endtask

   function automatic int sp_val();
      return int'($signed(sp_o));
   endfunction

   // Program a ramp, start it, and compare sp_o/irst_o/busy_o each cycle to the prediction.
   task automatic run_ramp(input int cur, input int tgt, input int st, input int iv,
                           input int ien, input int len);
      int seq[$];
      int s, n, d, ad, step_e, ivl_e, lead, total, m, spx;
      logic [31:0] rd;
      bus_wr(A_CURRENT, 32'(cur));
      bus_wr(A_TARGET, 32'(tgt));
      bus_wr(A_STEP, 32'(st));
      bus_wr(A_INTERVAL, 32'(iv));
      bus_wr(A_IRST_LEN, 32'(len));
      bus_wr(A_CTRL, 32'(ien << 2));
      step_e = (st == 0) ? 1 : st;
      ivl_e  = (iv == 0) ? 1 : iv;
      lead   = (ien != 0 && len != 0) ? len : 0;
      seq.push_back(cur);
      s = cur; n = 0;
      do begin
         n++;
         d  = tgt - s;
         ad = (d < 0) ? -d : d;
         if (ad <= step_e) s = tgt;
         else s = (d < 0) ? s - step_e : s + step_e;
         seq.push_back(s);
      end while (s != tgt);
      total = lead + n * ivl_e;
      bus_wr(A_CTRL, 32'((ien << 2) | 1));
      for (int k = 0; k <= total + 2; k++) begin
         if (k > 0) begin
            @(posedge clk_i);
            #1;
         end
         m = (k < lead) ? 0 : (k - lead) / ivl_e;
         if (m > n) m = n;
         spx = seq[m];
         check("ramp_sp", sp_val(), spx);
         check("ramp_irst", int'(irst_o), (k < lead) ? 1 : 0);
         check("ramp_busy", int'(busy_o), (k < total) ? 1 : 0);
      end
      bus_rd(A_STATUS, rd);
      check("end_status", int'(rd), 2);
      bus_rd(A_CURRENT, rd);
      check("end_current", int'(rd), tgt & ((1 << DW) - 1));
   endtask

   initial begin
      logic [31:0] rd;
      int cur, tgt, st, iv, ien, len, ad, step_e;
      sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
      rstn_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_sp", sp_val(), 0);
      check("rst_irst", int'(irst_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_ack", int'(sys_ack), 0);
      check("rst_rdata", int'(sys_rdata), 0);
      @(negedge clk_i);
      rstn_i = 1'b1;

      run_ramp(0, 100, 30, 4, 0, 0);
      check("r23_final", sp_val(), 100);
      run_ramp(50, -8192, 8191, 1, 0, 0);
      check("r24_final", sp_val(), -8192);
      run_ramp(0, 10, 10, 2, 1, 5);
      check("r25_final", sp_val(), 10);
      run_ramp(123, 123, 5, 3, 0, 0);

      for (int r = 0; r < 20; r++) begin
         cur = int'($urandom_range(0, 16383)) - 8192;
         tgt = int'($urandom_range(0, 16383)) - 8192;
         st  = int'($urandom_range(0, 8191));
         iv  = int'($urandom_range(0, 6));
         ien = int'($urandom_range(0, 1));
         len = int'($urandom_range(0, 6));
         ad  = (tgt > cur) ? tgt - cur : cur - tgt;
         step_e = (st == 0) ? 1 : st;
         if (ad / step_e > 40) st = ad / 40 + 1;
         run_ramp(cur, tgt, st, iv, ien, len);
      end

      // Abort mid-ramp holds the set-point and leaves done clear.
      bus_wr(A_CURRENT, 32'd0);
      bus_wr(A_TARGET, 32'd1000);
      bus_wr(A_STEP, 32'd1);
      bus_wr(A_INTERVAL, 32'd1);
      bus_wr(A_CTRL, 32'd1);
      repeat (20) @(posedge clk_i);
      #1;
      check("abort_pre_sp", sp_val(), 20);
      bus_wr(A_CTRL, 32'd2);
      check("abort_sp", sp_val(), 20);
      check("abort_busy", int'(busy_o), 0);
      repeat (3) @(posedge clk_i);
      #1;
      check("abort_hold", sp_val(), 20);
      bus_rd(A_STATUS, rd);
      check("abort_status", int'(rd), 0);
      bus_wr(A_CTRL, 32'd3);
      check("startabort_busy", int'(busy_o), 0);
      repeat (3) @(posedge clk_i);
      #1;
      check("startabort_idle", int'(busy_o), 0);
      check("startabort_sp", sp_val(), 20);

      // Asynchronous reset mid-ramp.
      bus_wr(A_CURRENT, 32'd0);
      bus_wr(A_TARGET, 32'd1000);
      bus_wr(A_STEP, 32'd10);
      bus_wr(A_INTERVAL, 32'd1);
      bus_wr(A_CTRL, 32'd1);
      repeat (30) @(posedge clk_i);
      #1;
      check("pre_rst_sp", sp_val(), 300);
      #2;
      rstn_i = 1'b0;
      #1;
      check("arst_sp", sp_val(), 0);
      check("arst_irst", int'(irst_o), 0);
      check("arst_busy", int'(busy_o), 0);
      check("arst_ack", int'(sys_ack), 0);
      check("arst_err", int'(sys_err), 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      for (int a = 0; a <= 7; a++) begin
         bus_rd(32'(a * 4), rd);
         check($sformatf("post_rst_rd%0d", a * 4), int'(rd), 0);
      end
      @(posedge clk_i);
      #1;
      check("ack_drop", int'(sys_ack), 0);
      check("post_rst_busy", int'(busy_o), 0);
      bus_wr(A_UNMAP, 32'hFFFF_FFFF);
      bus_rd(A_UNMAP, rd);
      check("unmap_rd", int'(rd), 0);
      check("err_low", int'(sys_err), 0);
      bus_wr(A_STEP, 32'hFFFF_FFFF);
      bus_rd(A_STEP, rd);
      check("step_width", int'(rd), 8191);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
